// File: rtl/fifo_push_arbiter.sv
// Arbitrates two symbol requesters onto one shared FIFO, one whole frame at a time.
// Latency: one grant cycle in IDLE, then one symbol per cycle straight through (combinational data path).
// Backpressure: fifo_full_i stalls the owner in place; the lock never switches mid-frame.
module fifo_push_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int FRAME_LEN  = 544,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s0_valid_i,
  input  logic [DATA_WIDTH-1:0] s0_data_i,
  input  logic                  s1_valid_i,
  input  logic [DATA_WIDTH-1:0] s1_data_i,
  output logic                  s0_ready_o,
  output logic                  s1_ready_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_push_o,
  output logic [DATA_WIDTH-1:0] fifo_data_o,
  output logic                  owner_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 last_owner_q, last_owner_d;
  logic                 frame_done_q, frame_done_d;

  logic lock0;
  logic lock1;
  logic last_sym;

  // Lock qualifiers are masked by reset so nothing leaks out while rst_i is high,
  // even before the state register has been cleared for the first time.
  assign lock0    = (state_q == LOCK0) && !rst_i;
  assign lock1    = (state_q == LOCK1) && !rst_i;
  assign last_sym = (cnt_q == CNT_WIDTH'(FRAME_LEN - 1));

  assign s0_ready_o   = lock0 && !fifo_full_i;
  assign s1_ready_o   = lock1 && !fifo_full_i;
  assign fifo_push_o  = (lock0 && s0_valid_i && !fifo_full_i) ||
                        (lock1 && s1_valid_i && !fifo_full_i);
  assign fifo_data_o  = lock0 ? s0_data_i : (lock1 ? s1_data_i : '0);
  assign busy_o       = (state_q != IDLE);
  assign owner_o      = (state_q == LOCK0) ? 1'b0 :
                        (state_q == LOCK1) ? 1'b1 : last_owner_q;
  assign frame_done_o = frame_done_q;

  // Next-state: grant in IDLE (round-robin on tie), count pushes while locked, release on last symbol.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_valid_i && s1_valid_i) begin
          if (last_owner_q) begin
            state_d      = LOCK0;
            last_owner_d = 1'b0;
          end else begin
            state_d      = LOCK1;
            last_owner_d = 1'b1;
          end
        end else if (s0_valid_i) begin
          state_d      = LOCK0;
          last_owner_d = 1'b0;
        end else if (s1_valid_i) begin
          state_d      = LOCK1;
          last_owner_d = 1'b1;
        end
      end
      LOCK0, LOCK1: begin
        if (fifo_push_o) begin
          if (last_sym) begin
            cnt_d        = '0;
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and frame bookkeeping registers; reset abandons any partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench: instance a uses the full 544-symbol frame, instance b a 4-symbol frame.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Protocol invariants are tallied every cycle and checked once at the end.
module tb_fifo_push_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a (FRAME_LEN = 544)
  logic       a_rst, a_s0_vld, a_s1_vld, a_full;
  logic [9:0] a_s0_dat, a_s1_dat, a_data;
  logic       a_s0_rdy, a_s1_rdy, a_push, a_owner, a_busy, a_done;
  // instance b (FRAME_LEN = 4)
  logic       b_rst, b_s0_vld, b_s1_vld, b_full;
  logic [9:0] b_s0_dat, b_s1_dat, b_data;
  logic       b_s0_rdy, b_s1_rdy, b_push, b_owner, b_busy, b_done;

  fifo_push_arbiter dut_a (
    .clk_i(clk), .rst_i(a_rst),
    .s0_valid_i(a_s0_vld), .s0_data_i(a_s0_dat),
    .s1_valid_i(a_s1_vld), .s1_data_i(a_s1_dat),
    .s0_ready_o(a_s0_rdy), .s1_ready_o(a_s1_rdy),
    .fifo_full_i(a_full), .fifo_push_o(a_push), .fifo_data_o(a_data),
    .owner_o(a_owner), .busy_o(a_busy), .frame_done_o(a_done)
  );

  fifo_push_arbiter #(.DATA_WIDTH(10), .FRAME_LEN(4), .CNT_WIDTH(2)) dut_b (
    .clk_i(clk), .rst_i(b_rst),
    .s0_valid_i(b_s0_vld), .s0_data_i(b_s0_dat),
    .s1_valid_i(b_s1_vld), .s1_data_i(b_s1_dat),
    .s0_ready_o(b_s0_rdy), .s1_ready_o(b_s1_rdy),
    .fifo_full_i(b_full), .fifo_push_o(b_push), .fifo_data_o(b_data),
    .owner_o(b_owner), .busy_o(b_busy), .frame_done_o(b_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // cycle counter and output monitors
  int cyc = 0;
  always @(posedge clk) cyc++;

  int         a_push_cnt = 0, a_done_cnt = 0;
  int         b_push_cnt = 0, b_done_cnt = 0;
  int         b_last_push_cyc = 0, b_done_cyc = 0;
  int         viol = 0;
  logic [9:0] b_q[$];

  always @(negedge clk) begin
    if (a_push) a_push_cnt++;
    if (a_done) a_done_cnt++;
    if (b_push) begin
      b_push_cnt++;
      b_q.push_back(b_data);
      b_last_push_cyc = cyc;
    end
    if (b_done) begin
      b_done_cnt++;
      b_done_cyc = cyc;
    end
    if ((a_push && a_full) || (a_s0_rdy && a_s1_rdy) ||
        (b_push && b_full) || (b_s0_rdy && b_s1_rdy)) viol++;
  end

  // Wait (bounded) for a frame_done pulse; returns on the falling edge where it is seen.
  task automatic wait_done(input bit sel, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((sel ? b_done : a_done) == 1'b0) && n < 3000);
    chk({tag, "_done_seen"}, 32'(sel ? b_done : a_done), 1);
  endtask

  int pa, pb, pd, guard;
  bit stalled;

  initial begin
    a_rst = 1; a_s0_vld = 1; a_s1_vld = 1; a_full = 0;
    a_s0_dat = 10'h155; a_s1_dat = 10'h2aa;
    b_rst = 1; b_s0_vld = 0; b_s1_vld = 0; b_full = 0;
    b_s0_dat = '0; b_s1_dat = 10'h3c3;

    // ---- reset behaviour ----
    @(posedge clk);
    @(negedge clk);
    chk("rst_a_s0_rdy", 32'(a_s0_rdy), 0);
    chk("rst_a_s1_rdy", 32'(a_s1_rdy), 0);
    chk("rst_a_push",   32'(a_push),   0);
    chk("rst_a_data",   32'(a_data),   0);
    chk("rst_a_done",   32'(a_done),   0);
    chk("rst_b_push",   32'(b_push),   0);
    @(posedge clk); #1;
    a_rst = 0; b_rst = 0;
    pa = a_push_cnt;
    @(negedge clk);
    chk("post_rst_a_busy",  32'(a_busy),   0);
    chk("post_rst_a_push",  32'(a_push),   0);
    chk("post_rst_a_s0rdy", 32'(a_s0_rdy), 0);
    chk("post_rst_a_owner", 32'(a_owner),  1);
    chk("post_rst_a_data",  32'(a_data),   0);
    chk("post_rst_b_owner", 32'(b_owner),  1);
    @(negedge clk);
    chk("tie_grant_owner", 32'(a_owner),  0);
    chk("tie_grant_busy",  32'(a_busy),   1);
    chk("tie_grant_s0rdy", 32'(a_s0_rdy), 1);
    chk("tie_grant_s1rdy", 32'(a_s1_rdy), 0);
    chk("tie_grant_push",  32'(a_push),   1);
    chk("tie_grant_data",  32'(a_data),   32'h155);

    // ---- b: s0 only, 4-symbol frame, full for 5 cycles on the 3rd symbol ----
    @(posedge clk); #1;
    pb = b_push_cnt;
    b_s0_vld = 1;
    b_s0_dat = 10'd100;
    guard = 0;
    stalled = 0;
    while (b_push_cnt - pb < 4 && guard < 60) begin
      @(posedge clk); #1;
      guard++;
      if (b_push_cnt - pb < 4) b_s0_dat = 10'(100 + b_push_cnt - pb);
      if (b_push_cnt - pb == 2 && !stalled) begin
        stalled = 1;
        b_full = 1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_push",  32'(b_push),   0);
          chk("stall_s0rdy", 32'(b_s0_rdy), 0);
          chk("stall_busy",  32'(b_busy),   1);
          @(posedge clk); #1;
        end
        b_full = 0;
        chk("stall_cnt_frozen", 32'(b_push_cnt - pb), 2);
      end
    end
    b_s0_vld = 0;
    @(negedge clk);
    chk("b_done_pulse", 32'(b_done), 1);
    chk("b_done_idle",  32'(b_busy), 0);
    @(negedge clk);
    chk("b_done_one_cycle", 32'(b_done), 0);
    chk("b_push_total",     32'(b_push_cnt - pb), 4);
    chk("b_queue_size",     32'(b_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < b_q.size()) chk("b_order", 32'(b_q[i]), 32'(100 + i));
    end
    chk("b_done_after_last", 32'(b_done_cyc - b_last_push_cyc), 1);

    // ---- b: s1 alone with continuous valid ----
    @(posedge clk); #1;
    pb = b_push_cnt;
    b_s1_vld = 1;
    wait_done(1'b1, "b_s1_f1");
    chk("b_s1_f1_pushes", 32'(b_push_cnt - pb), 4);
    chk("b_s1_gap_idle",  32'(b_busy), 0);
    pb = b_push_cnt;
    @(negedge clk);
    chk("b_s1_regrant_busy",  32'(b_busy),  1);
    chk("b_s1_regrant_owner", 32'(b_owner), 1);
    chk("b_s1_regrant_push",  32'(b_push),  1);
    wait_done(1'b1, "b_s1_f2");
    chk("b_s1_f2_pushes", 32'(b_push_cnt - pb), 4);
    chk("b_s1_gap2_idle", 32'(b_busy), 0);
    @(posedge clk); #1;
    b_s1_vld = 0;

    // ---- a: first frame (s0) completes, s1 next ----
    wait_done(1'b0, "a_f1");
    chk("a_f1_pushes",     32'(a_push_cnt - pa), 544);
    chk("a_f1_idle",       32'(a_busy),  0);
    chk("a_f1_idle_owner", 32'(a_owner), 0);
    pa = a_push_cnt;
    @(negedge clk);
    chk("a_f2_owner", 32'(a_owner),  1);
    chk("a_f2_busy",  32'(a_busy),   1);
    chk("a_f2_s1rdy", 32'(a_s1_rdy), 1);
    chk("a_f2_data",  32'(a_data),   32'h2aa);
    chk("a_f1_done_one_cycle", 32'(a_done), 0);

    // ---- a: owner s1 pauses for 3 cycles while s0 keeps requesting ----
    repeat (5) begin
      @(posedge clk); #1;
    end
    a_s1_vld = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap_s0rdy", 32'(a_s0_rdy), 0);
      chk("gap_busy",  32'(a_busy),   1);
      chk("gap_owner", 32'(a_owner),  1);
      chk("gap_push",  32'(a_push),   0);
      @(posedge clk); #1;
    end
    a_s1_vld = 1;
    wait_done(1'b0, "a_f2");
    chk("a_f2_pushes", 32'(a_push_cnt - pa), 544);
    pa = a_push_cnt;
    @(negedge clk);
    chk("a_f3_owner", 32'(a_owner), 0);
    chk("a_f3_busy",  32'(a_busy),  1);

    // ---- a: reset after 100 symbols of an s0 frame ----
    guard = 0;
    while (a_push_cnt - pa < 100 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    a_rst = 1;
    a_s1_vld = 0;
    pd = a_done_cnt;
    @(negedge clk);
    chk("midrst_push",  32'(a_push),   0);
    chk("midrst_s0rdy", 32'(a_s0_rdy), 0);
    chk("midrst_done",  32'(a_done),   0);
    @(posedge clk); #1;
    a_rst = 0;
    chk("midrst_partial", 32'(a_push_cnt - pa), 100);
    pa = a_push_cnt;
    @(negedge clk);
    chk("midrst_after_busy", 32'(a_busy), 0);
    chk("midrst_after_push", 32'(a_push), 0);
    chk("midrst_after_done", 32'(a_done), 0);
    wait_done(1'b0, "a_f4");
    chk("a_f4_pushes", 32'(a_push_cnt - pa), 544);
    @(posedge clk); #1;
    chk("a_f4_done_count", 32'(a_done_cnt - pd), 1);

    chk("invariants", 32'(viol), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
